// File: rtl/down_counter_timer_module.sv
// Loadable binary down counter with terminal-count pulse.
// Supports one-shot and auto-reload (periodic tick) operation.
module down_counter_timer_module #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;

  // State register: reset clears everything, including the reload value
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
    end
  end

  // Next-state logic: load beats enable; enable only matters in RUN
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    tc_d     = 1'b0;

    if (load) begin
      count_d  = load_val;
      reload_d = load_val;
      state_d  = (load_val != '0) ? S_RUN : S_DONE;
    end else begin
      unique case (state_q)
        S_RUN: begin
          if (en) begin
            if (count_q > WIDTH'(1)) begin
              count_d = count_q - WIDTH'(1);
            end else if (count_q == WIDTH'(1)) begin
              count_d = '0;
              tc_d    = 1'b1;
              if (!auto_reload) state_d = S_DONE;
            end else if (auto_reload) begin
              // Zero is held for one enabled cycle, giving an N+1 period
              count_d = reload_q;
            end else begin
              state_d = S_DONE;
            end
          end
        end
        S_DONE: begin
          count_d = '0;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Output decode from registered state
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state_q)
      S_RUN:   busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  assign count = count_q;
  assign tc    = tc_q;

endmodule

// File: tb/tb_down_counter_timer_module.sv
// Bench for down_counter_timer_module: directed test-plan sequences plus
// randomized traffic, all checked against a behavioural timer model.
module tb_down_counter_timer_module;
  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst, load, en, auto_reload;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             tc, busy, done;

  int n_cmp  = 0;
  int n_fail = 0;

  // Behavioural model: remaining ticks, programmed period, and activity flags
  int m_cnt      = 0;
  int m_rel      = 0;
  bit m_tc       = 1'b0;
  bit m_counting = 1'b0;
  bit m_finished = 1'b0;
  bit prev_tc    = 1'b0;

  down_counter_timer_module #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .load_val   (load_val),
    .en         (en),
    .auto_reload(auto_reload),
    .count      (count),
    .tc         (tc),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input bit r, input bit l, input int v, input bit e, input bit a);
    if (r) begin
      m_cnt = 0; m_rel = 0; m_tc = 0; m_counting = 0; m_finished = 0;
    end else if (l) begin
      m_cnt = v; m_rel = v; m_tc = 0;
      m_counting = (v != 0);
      m_finished = (v == 0);
    end else if (m_counting && e) begin
      m_tc = 0;
      if (m_cnt >= 2) m_cnt = m_cnt - 1;
      else if (m_cnt == 1) begin
        m_cnt = 0;
        m_tc  = 1;
        if (!a) begin m_counting = 0; m_finished = 1; end
      end else if (a) m_cnt = m_rel;
      else begin m_counting = 0; m_finished = 1; end
    end else begin
      m_tc = 0;
    end
  endtask

  // One clock: drive on falling edge, model the rising edge, check just after
  task automatic step(input bit r, input bit l, input logic [WIDTH-1:0] v, input bit e, input bit a);
    @(negedge clk);
    rst = r; load = l; load_val = v; en = e; auto_reload = a;
    @(posedge clk);
    model_edge(r, l, int'(v), e, a);
    #1;
    chk("count", 32'(count), 32'(m_cnt));
    chk("tc",    32'(tc),    32'(m_tc));
    chk("busy",  32'(busy),  32'(m_counting));
    chk("done",  32'(done),  32'(m_finished));
    chk("tc_twice", 32'(prev_tc & tc), 32'd0);
    prev_tc = tc;
  endtask

  initial begin
    rst = 1'b0; load = 1'b0; load_val = '0; en = 1'b0; auto_reload = 1'b0;

    // Reset with load and en also high
    step(1, 1, 4'd5, 1, 0);
    step(1, 1, 4'd5, 1, 0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_flags", {29'd0, tc, busy, done}, 32'd0);
    step(0, 0, 4'd0, 1, 0);
    step(0, 0, 4'd0, 1, 0);
    chk("idle_en_count", 32'(count), 32'd0);

    // One-shot, N=5
    step(0, 1, 4'd5, 1, 0);
    chk("os_load", 32'(count), 32'd5);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 4'd0, 1, 0);
      chk("os_seq", 32'(count), 32'(4 - i));
      chk("os_tc", 32'(tc), 32'(i == 4));
    end
    chk("os_done", {30'd0, busy, done}, 32'd1);
    for (int i = 0; i < 10; i++) step(0, 0, 4'd0, 1, 0);
    chk("os_hold", 32'(count), 32'd0);

    // Auto-reload, N=3: 3,2,1,0,3,...
    step(0, 1, 4'd3, 1, 1);
    for (int i = 1; i <= 12; i++) begin
      step(0, 0, 4'd0, 1, 1);
      chk("ar_seq", 32'(count), 32'(3 - (i % 4)));
      chk("ar_tc", 32'(tc), 32'((i % 4) == 3));
      chk("ar_flags", {30'd0, busy, done}, 32'd2);
    end

    // Enable gating
    begin
      bit     en_pat [7]  = '{1, 0, 0, 1, 1, 0, 1};
      int     exp_c  [7]  = '{3, 3, 3, 2, 1, 1, 0};
      step(0, 1, 4'd4, 1, 0);
      chk("eg_load", 32'(count), 32'd4);
      for (int i = 0; i < 7; i++) begin
        step(0, 0, 4'd0, en_pat[i], 0);
        chk("eg_seq", 32'(count), 32'(exp_c[i]));
        chk("eg_tc", 32'(tc), 32'(i == 6));
      end
    end

    // Reload mid-count from 6 to 2
    step(0, 1, 4'd9, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 4'd0, 1, 0);
    chk("rl_before", 32'(count), 32'd6);
    step(0, 1, 4'd2, 1, 0);
    chk("rl_load", {27'd0, count, tc}, {27'd0, 4'd2, 1'b0});
    step(0, 0, 4'd0, 1, 0);
    chk("rl_1", {27'd0, count, tc}, {27'd0, 4'd1, 1'b0});
    step(0, 0, 4'd0, 1, 0);
    chk("rl_0", {27'd0, count, tc}, {27'd0, 4'd0, 1'b1});

    // load_val = 0 goes straight to DONE without tc
    step(0, 1, 4'd0, 1, 1);
    chk("z_done", {29'd0, tc, busy, done}, 32'd1);
    step(0, 0, 4'd0, 1, 1);
    chk("z_tc", 32'(tc), 32'd0);

    // Full-scale load: 15 enabled cycles to tc, no wrap
    step(0, 1, 4'd15, 1, 0);
    for (int i = 1; i <= 15; i++) begin
      step(0, 0, 4'd0, 1, 0);
      chk("fs_tc", 32'(tc), 32'(i == 15));
    end
    step(0, 0, 4'd0, 1, 0);
    chk("fs_nowrap", 32'(count), 32'd0);

    // Reset while count=7
    step(0, 1, 4'd9, 1, 1);
    step(0, 0, 4'd0, 1, 1);
    step(0, 0, 4'd0, 1, 1);
    chk("mr_before", 32'(count), 32'd7);
    step(1, 0, 4'd0, 1, 1);
    chk("mr_reset", {27'd0, count, tc, busy, done}, 32'd0);

    // auto_reload dropped while count is 0
    step(0, 1, 4'd2, 1, 1);
    step(0, 0, 4'd0, 1, 1);
    step(0, 0, 4'd0, 1, 1);
    chk("ad_zero", {27'd0, count, tc}, {27'd0, 4'd0, 1'b1});
    step(0, 0, 4'd0, 1, 0);
    chk("ad_done", {27'd0, count, tc, busy, done}, {27'd0, 4'd0, 1'b0, 1'b0, 1'b1});

    // Randomized traffic against the model
    begin
      bit a = 1'b1;
      for (int i = 0; i < 400; i++) begin
        if ($urandom_range(0, 15) == 0) a = ~a;
        step(($urandom_range(0, 63) == 0),
             ($urandom_range(0, 9) == 0),
             4'($urandom_range(0, 15)),
             ($urandom_range(0, 3) != 0),
             a);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/down_counter_timer_module.md
Name: down_counter_timer_module

Overview:
- Synchronous, loadable binary down counter with terminal-count detection. It is the count-down companion to the team's up-counting ripple counter.
- Used as a programmable delay or periodic tick generator. A value is loaded, and the block decrements once per enabled clock until it reaches zero.
- Supports one-shot and auto-reload modes.
- Fully synchronous: every flop is clocked by clk. There are no derived clocks.

Parameters:
- WIDTH, 4, counter width in bits; legal range 2 to 16.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- load  input  1  when high, captures load_val and (re)starts the count.
- load_val  input  WIDTH  start/reload value N.
- en  input  1  count enable; decrement happens only on cycles with en=1.
- auto_reload  input  1  1 = periodic mode, 0 = one-shot mode. Sampled live each cycle.
- count  output  WIDTH  current counter value (registered).
- tc  output  1  terminal-count pulse: high for exactly one cycle when count steps 1 -> 0.
- busy  output  1  high while in RUN.
- done  output  1  high while in DONE; one-shot completion flag.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset (rst=1 at a rising edge): state=IDLE, count=0, reload_reg=0, tc=0, busy=0, done=0. rst overrides load and en.
- Internal: reload_reg (WIDTH bits) holds the last loaded N.
- FSM states: IDLE, RUN, DONE. busy=1 only in RUN; done=1 only in DONE. Both are registered and decoded from state.
- Priority each cycle: rst > load > en.
- load=1 (any state):
  - count<=load_val, reload_reg<=load_val, tc<=0.
  - If load_val!=0: go to RUN. If load_val==0: go to DONE.
  - en on the same cycle is ignored; no decrement occurs.
- IDLE: count holds; en is ignored; leave only via load.
- RUN, en=0: count holds, tc<=0, stay in RUN.
- RUN, en=1, count>1: count<=count-1, tc<=0.
- RUN, en=1, count==1: count<=0, tc<=1.
  - If auto_reload=0: go to DONE.
  - If auto_reload=1: stay in RUN.
- RUN, en=1, count==0 (reachable only in auto-reload mode): count<=reload_reg, tc<=0.
  - If auto_reload has dropped to 0 by this cycle: go to DONE instead and count holds 0.
- Auto-reload period: N+1 enabled cycles per tc pulse. Example: N=3 gives the sequence 3,2,1,0,3,2,...
- DONE: count holds 0, tc=0, en is ignored; leave only via load or rst.
- tc is registered and asserts on the same edge that count becomes 0. It is never high for two consecutive cycles.
- Arithmetic: the count never wraps below 0. The decrement is unsigned modulo-free.
- Timing: load_val=N with en held high gives first tc N cycles after the load edge.
- Reset mid-count: all state returns to reset values at that edge; reload_reg is cleared.
- Load mid-count: restarts cleanly from the new value. No tc is emitted for the aborted count.

Test Plan:
- Reset: rst=1 for 2 cycles with en=1 and load=1 -> count=0, tc=0, busy=0, done=0, state IDLE; en alone afterwards leaves count=0.
- One-shot: load_val=5, auto_reload=0, en=1 continuously -> count 5,4,3,2,1,0; tc=1 only on the cycle count=0 (5 cycles after load); done=1, busy=0; count stays 0 for 10 more cycles.
- Auto-reload: load_val=3, auto_reload=1, en=1 for 12 cycles -> count 3,2,1,0,3,2,1,0,3,...; tc pulses every 4 cycles; busy stays 1; done stays 0.
- Enable gating: load_val=4, en toggled 1,0,0,1,1,0,1 -> count decrements only on en=1 cycles: 4,3,3,3,2,1,1,0; tc on the final cycle only.
- Reload/edge cases:
  - load_val=9 reloaded to 2 while count=6 -> count 2,1,0; no extra tc.
  - load_val=0 -> immediate DONE, tc never asserts.
  - WIDTH=4, load_val=15 -> 15 cycles to tc, no wrap.
- Mid-run controls:
  - rst asserted while count=7 in RUN -> next cycle all outputs are at reset values.
  - auto_reload dropped while count=0 -> DONE with count held at 0.
